// File: rtl/pieo_enq_fifo_tracker.sv
// pieo_enq_fifo_tracker
// Tracks per-flow FIFOs that hold data but have no PIEO entry and presents
// them one at a time, round-robin, to the pre-enqueue stage. A FIFO is marked
// enqueued on an accepted trigger and released when post-dequeue serves it.
module pieo_enq_fifo_tracker #(
    parameter int NUM_FIFO          = 3,
    parameter int ID_LOG            = 2,
    parameter int FIFO_STATUS_WIDTH = 12,
    parameter int CNT_WIDTH         = $clog2(NUM_FIFO + 1)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_FIFO*FIFO_STATUS_WIDTH-1:0] fifo_status_depth,
    input  logic                                  pieo_enq_trigger,
    input  logic                                  release_valid,
    input  logic [ID_LOG-1:0]                     release_fifo_id,
    output logic                                  fifos_not_enq_flag,
    output logic [ID_LOG-1:0]                     fifo_id,
    output logic [NUM_FIFO-1:0]                   in_pieo,
    output logic [CNT_WIDTH-1:0]                  enq_count
);

    // Number of set bits in an enqueued-mark bitmap.
    function automatic logic [CNT_WIDTH-1:0] popcount(input logic [NUM_FIFO-1:0] v);
        logic [CNT_WIDTH-1:0] c;
        c = {CNT_WIDTH{1'b0}};
        for (int i = 0; i < NUM_FIFO; i++) begin
            c = c + CNT_WIDTH'(v[i]);
        end
        return c;
    endfunction

    logic [ID_LOG-1:0]    rr_ptr_r;

    logic                 accept_s;
    logic [NUM_FIFO-1:0]  set_s;
    logic [NUM_FIFO-1:0]  clr_s;
    logic [NUM_FIFO-1:0]  in_pieo_next_s;
    logic [NUM_FIFO-1:0]  elig_s;
    logic                 cur_elig_s;
    logic                 hold_s;
    logic [ID_LOG-1:0]    rr_ptr_next_s;
    logic [ID_LOG:0]      cand_s;
    logic                 hit_s;
    logic                 found_s;
    logic [ID_LOG-1:0]    found_id_s;
    logic                 flag_next_s;
    logic [ID_LOG-1:0]    id_next_s;
    logic [CNT_WIDTH-1:0] cnt_next_s;

    // Bitmap update, eligibility, hold decision and round-robin search.
    always_comb begin
        accept_s       = pieo_enq_trigger & fifos_not_enq_flag;
        set_s          = {NUM_FIFO{1'b0}};
        clr_s          = {NUM_FIFO{1'b0}};
        elig_s         = {NUM_FIFO{1'b0}};
        cur_elig_s     = 1'b0;
        cand_s         = {(ID_LOG+1){1'b0}};
        hit_s          = 1'b0;
        found_s        = 1'b0;
        found_id_s     = fifo_id;

        // Out-of-range release ids match no bit, so they are naturally ignored;
        // clearing a bit that is already 0 is likewise a no-op.
        for (int i = 0; i < NUM_FIFO; i++) begin
            set_s[i] = accept_s & (fifo_id == ID_LOG'(i));
            clr_s[i] = release_valid & (release_fifo_id == ID_LOG'(i));
        end
        in_pieo_next_s = (in_pieo | set_s) & ~clr_s;

        for (int i = 0; i < NUM_FIFO; i++) begin
            elig_s[i]  = (fifo_status_depth[i*FIFO_STATUS_WIDTH +: FIFO_STATUS_WIDTH]
                          != {FIFO_STATUS_WIDTH{1'b0}}) & ~in_pieo_next_s[i];
            cur_elig_s = cur_elig_s | ((fifo_id == ID_LOG'(i)) & elig_s[i]);
        end

        // An unserved, still-eligible request keeps its id and the pointer.
        hold_s = fifos_not_enq_flag & ~accept_s & cur_elig_s;

        if (accept_s) begin
            rr_ptr_next_s = (fifo_id == ID_LOG'(NUM_FIFO - 1)) ? {ID_LOG{1'b0}}
                                                                : fifo_id + ID_LOG'(1);
        end else begin
            rr_ptr_next_s = rr_ptr_r;
        end

        // Circular search starting at the next pointer, wrapping mod NUM_FIFO.
        for (int k = 0; k < NUM_FIFO; k++) begin
            cand_s = {1'b0, rr_ptr_next_s} + (ID_LOG+1)'(k);
            cand_s = (cand_s >= (ID_LOG+1)'(NUM_FIFO)) ? cand_s - (ID_LOG+1)'(NUM_FIFO)
                                                        : cand_s;
            for (int i = 0; i < NUM_FIFO; i++) begin
                hit_s      = ~found_s & elig_s[i] & (cand_s == (ID_LOG+1)'(i));
                found_id_s = hit_s ? ID_LOG'(i) : found_id_s;
                found_s    = found_s | hit_s;
            end
        end

        if (hold_s) begin
            flag_next_s = fifos_not_enq_flag;
            id_next_s   = fifo_id;
        end else begin
            flag_next_s = found_s;
            id_next_s   = found_id_s;
        end

        cnt_next_s = popcount(in_pieo_next_s);
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_pieo            <= {NUM_FIFO{1'b0}};
            rr_ptr_r           <= {ID_LOG{1'b0}};
            fifos_not_enq_flag <= 1'b0;
            fifo_id            <= {ID_LOG{1'b0}};
            enq_count          <= {CNT_WIDTH{1'b0}};
        end else begin
            in_pieo            <= in_pieo_next_s;
            rr_ptr_r           <= rr_ptr_next_s;
            fifos_not_enq_flag <= flag_next_s;
            fifo_id            <= id_next_s;
            enq_count          <= cnt_next_s;
        end
    end

endmodule

// File: tb/tb_pieo_enq_fifo_tracker.sv
// Self-checking bench for pieo_enq_fifo_tracker: directed scenarios with
// constant expectations, then randomized traffic against a behavioural model.
module tb_pieo_enq_fifo_tracker;

    localparam int NF = 3;
    localparam int IL = 2;
    localparam int W  = 12;
    localparam int CW = $clog2(NF + 1);

    logic            clk = 1'b0;
    logic            rst;
    logic [NF*W-1:0] depth;
    logic            trig;
    logic            rv;
    logic [IL-1:0]   rid;
    logic            flag;
    logic [IL-1:0]   id;
    logic [NF-1:0]   inp;
    logic [CW-1:0]   cnt;

    int checks   = 0;
    int failures = 0;

    pieo_enq_fifo_tracker #(
        .NUM_FIFO(NF), .ID_LOG(IL), .FIFO_STATUS_WIDTH(W), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .fifo_status_depth(depth),
        .pieo_enq_trigger(trig), .release_valid(rv), .release_fifo_id(rid),
        .fifos_not_enq_flag(flag), .fifo_id(id), .in_pieo(inp), .enq_count(cnt)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_depth(input int i, input int v);
        depth[i*W +: W] = W'(v);
    endtask

    task automatic do_reset();
        rst = 1'b1; depth = '0; trig = 1'b0; rv = 1'b0; rid = '0;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; depth = '0; trig = 1'b0; rv = 1'b0; rid = '0;
        cyc(); cyc();
        checks += 4;
        if (flag !== 1'b0) begin failures++; $display("FAIL reset_flag: got %0h expected 0", flag); end
        if (id !== 2'd0) begin failures++; $display("FAIL reset_id: got %0h expected 0", id); end
        if (inp !== 3'b000) begin failures++; $display("FAIL reset_in_pieo: got %0b expected 000", inp); end
        if (cnt !== 2'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", cnt); end
        rst = 1'b0;
        cyc(); cyc(); cyc();
        checks++;
        if (flag !== 1'b0) begin failures++; $display("FAIL idle_flag: got %0h expected 0", flag); end
    endtask

    task automatic test_first_enq();
        do_reset();
        set_depth(1, 5);
        cyc();
        checks += 2;
        if (flag !== 1'b1) begin failures++; $display("FAIL first_flag: got %0h expected 1", flag); end
        if (id !== 2'd1) begin failures++; $display("FAIL first_id: got %0d expected 1", id); end
        trig = 1'b1;
        cyc();
        trig = 1'b0;
        checks += 3;
        if (inp !== 3'b010) begin failures++; $display("FAIL first_in_pieo: got %0b expected 010", inp); end
        if (cnt !== 2'd1) begin failures++; $display("FAIL first_count: got %0d expected 1", cnt); end
        if (flag !== 1'b0) begin failures++; $display("FAIL first_flag_after: got %0h expected 0", flag); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_depth(0, 5); set_depth(1, 7); set_depth(2, 9);
        cyc();
        checks += 2;
        if (flag !== 1'b1) begin failures++; $display("FAIL b2b_flag0: got %0h expected 1", flag); end
        if (id !== 2'd0) begin failures++; $display("FAIL b2b_id0: got %0d expected 0", id); end
        trig = 1'b1;
        cyc();
        checks += 2;
        if (id !== 2'd1) begin failures++; $display("FAIL b2b_id1: got %0d expected 1", id); end
        if (inp !== 3'b001) begin failures++; $display("FAIL b2b_in_pieo1: got %0b expected 001", inp); end
        cyc();
        checks++;
        if (id !== 2'd2) begin failures++; $display("FAIL b2b_id2: got %0d expected 2", id); end
        cyc();
        trig = 1'b0;
        checks += 3;
        if (flag !== 1'b0) begin failures++; $display("FAIL b2b_flag_end: got %0h expected 0", flag); end
        if (inp !== 3'b111) begin failures++; $display("FAIL b2b_in_pieo: got %0b expected 111", inp); end
        if (cnt !== 2'd3) begin failures++; $display("FAIL b2b_count: got %0d expected 3", cnt); end
        // release id 1 from the full state
        rv = 1'b1; rid = 2'd1;
        cyc();
        rv = 1'b0;
        checks += 4;
        if (flag !== 1'b1) begin failures++; $display("FAIL rel_flag: got %0h expected 1", flag); end
        if (id !== 2'd1) begin failures++; $display("FAIL rel_id: got %0d expected 1", id); end
        if (cnt !== 2'd2) begin failures++; $display("FAIL rel_count: got %0d expected 2", cnt); end
        if (inp !== 3'b101) begin failures++; $display("FAIL rel_in_pieo: got %0b expected 101", inp); end
        trig = 1'b1;
        cyc();
        trig = 1'b0;
        checks += 2;
        if (cnt !== 2'd3) begin failures++; $display("FAIL rel_count_back: got %0d expected 3", cnt); end
        if (flag !== 1'b0) begin failures++; $display("FAIL rel_flag_back: got %0h expected 0", flag); end
    endtask

    task automatic test_hold_wrap_and_release();
        do_reset();
        set_depth(2, 4);
        cyc();
        checks += 2;
        if (flag !== 1'b1) begin failures++; $display("FAIL hold_flag: got %0h expected 1", flag); end
        if (id !== 2'd2) begin failures++; $display("FAIL hold_id_start: got %0d expected 2", id); end
        set_depth(0, 3);
        for (int c = 0; c < 10; c++) begin
            cyc();
            checks++;
            if (id !== 2'd2 || flag !== 1'b1) begin
                failures++;
                $display("FAIL hold_id cycle %0d: got flag=%0h id=%0d expected flag=1 id=2", c, flag, id);
            end
        end
        trig = 1'b1;
        cyc();
        trig = 1'b0;
        checks += 2;
        if (id !== 2'd0 || flag !== 1'b1) begin failures++; $display("FAIL wrap_id: got flag=%0h id=%0d expected flag=1 id=0", flag, id); end
        if (inp !== 3'b100) begin failures++; $display("FAIL wrap_in_pieo: got %0b expected 100", inp); end
        // trigger of id 0 and release of id 2 together; depth[1] stays 0
        trig = 1'b1; rv = 1'b1; rid = 2'd2;
        cyc();
        trig = 1'b0; rv = 1'b0;
        checks += 3;
        if (inp !== 3'b001) begin failures++; $display("FAIL both_in_pieo: got %0b expected 001", inp); end
        if (cnt !== 2'd1) begin failures++; $display("FAIL both_count: got %0d expected 1", cnt); end
        if (id !== 2'd2 || flag !== 1'b1) begin failures++; $display("FAIL both_id: got flag=%0h id=%0d expected flag=1 id=2", flag, id); end
        // out-of-range release, then release of a non-enqueued id
        rv = 1'b1; rid = 2'd3;
        cyc();
        checks += 2;
        if (inp !== 3'b001 || cnt !== 2'd1) begin failures++; $display("FAIL rel_oob: got in_pieo=%0b count=%0d expected 001/1", inp, cnt); end
        if (id !== 2'd2 || flag !== 1'b1) begin failures++; $display("FAIL rel_oob_id: got flag=%0h id=%0d expected 1/2", flag, id); end
        rid = 2'd1;
        cyc();
        rv = 1'b0;
        checks += 2;
        if (inp !== 3'b001 || cnt !== 2'd1) begin failures++; $display("FAIL rel_notenq: got in_pieo=%0b count=%0d expected 001/1", inp, cnt); end
        if (id !== 2'd2 || flag !== 1'b1) begin failures++; $display("FAIL rel_notenq_id: got flag=%0h id=%0d expected 1/2", flag, id); end
    endtask

    task automatic test_mid_reset();
        // continues from in_pieo=001 with id 2 presented
        set_depth(1, 6);
        trig = 1'b1;
        cyc();
        checks++;
        if (id !== 2'd1 || inp !== 3'b101) begin failures++; $display("FAIL fill_step: got id=%0d in_pieo=%0b expected 1/101", id, inp); end
        cyc();
        trig = 1'b0;
        checks++;
        if (inp !== 3'b111) begin failures++; $display("FAIL fill_full: got %0b expected 111", inp); end
        rst = 1'b1;
        cyc();
        checks++;
        if (flag !== 1'b0 || id !== 2'd0 || inp !== 3'b000 || cnt !== 2'd0) begin
            failures++;
            $display("FAIL midrst_clear: got flag=%0h id=%0d in_pieo=%0b count=%0d expected all 0", flag, id, inp, cnt);
        end
        rst = 1'b0;
        cyc();
        checks++;
        if (flag !== 1'b1 || id !== 2'd0) begin failures++; $display("FAIL midrst_represent: got flag=%0h id=%0d expected 1/0", flag, id); end
    endtask

    task automatic test_random();
        bit m_in [NF];
        bit nxt [NF];
        bit el [NF];
        bit m_flag;
        int m_id, m_ptr, m_cnt, start, idx;
        bit acc, found;
        logic [NF-1:0] exp_in;
        do_reset();
        for (int i = 0; i < NF; i++) m_in[i] = 1'b0;
        m_flag = 1'b0; m_id = 0; m_ptr = 0; m_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NF; i++) set_depth(i, ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 4095));
            trig = $urandom_range(0, 1) == 1;
            rv   = $urandom_range(0, 2) == 0;
            rid  = IL'($urandom_range(0, 3));
            rst  = $urandom_range(0, 99) == 0;
            if (rst) begin
                for (int i = 0; i < NF; i++) m_in[i] = 1'b0;
                m_flag = 1'b0; m_id = 0; m_ptr = 0; m_cnt = 0;
            end else begin
                acc = trig && m_flag;
                for (int i = 0; i < NF; i++) nxt[i] = m_in[i];
                if (acc) nxt[m_id] = 1'b1;
                if (rv && int'(rid) < NF) nxt[int'(rid)] = 1'b0;
                for (int i = 0; i < NF; i++) el[i] = (depth[i*W +: W] != 0) && !nxt[i];
                if (!(m_flag && !acc && el[m_id])) begin
                    start = acc ? (m_id + 1) % NF : m_ptr;
                    m_ptr = start;
                    found = 1'b0;
                    for (int k = 0; k < NF; k++) begin
                        idx = (start + k) % NF;
                        if (!found && el[idx]) begin found = 1'b1; m_id = idx; end
                    end
                    m_flag = found;
                end
                m_cnt = 0;
                for (int i = 0; i < NF; i++) begin m_in[i] = nxt[i]; m_cnt += int'(nxt[i]); end
            end
            for (int i = 0; i < NF; i++) exp_in[i] = m_in[i];
            cyc();
            checks += 4;
            if (flag !== m_flag) begin failures++; $display("FAIL rnd_flag cycle %0d: got %0h expected %0h", c, flag, m_flag); end
            if (id !== IL'(m_id)) begin failures++; $display("FAIL rnd_id cycle %0d: got %0d expected %0d", c, id, m_id); end
            if (inp !== exp_in) begin failures++; $display("FAIL rnd_in_pieo cycle %0d: got %0b expected %0b", c, inp, exp_in); end
            if (cnt !== CW'(m_cnt)) begin failures++; $display("FAIL rnd_count cycle %0d: got %0d expected %0d", c, cnt, m_cnt); end
        end
        rst = 1'b0; trig = 1'b0; rv = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_enq();
        test_back_to_back();
        test_hold_wrap_and_release();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
